// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage of the single-cycle MIPS datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

   localparam int PC_W = 32;

   // Default reset vector; it must stay word aligned.
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // RUN fetches normally. HALT freezes the PC, and only reset leaves it.
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } pc_state_t;

endpackage : cpu_pkg

// File: rtl/adder32.sv
// 32-bit modulo adder; the carry out of bit 31 is dropped.
// Latency: combinational, zero cycles.
// Backpressure: none (pure datapath).
module adder32
   import cpu_pkg::*;
(
   input  logic [PC_W-1:0] a,
   input  logic [PC_W-1:0] b,
   output logic [PC_W-1:0] sum
);

   // Wraps modulo 2^32 because the result is truncated to PC_W bits.
   assign sum = a + b;

endmodule : adder32

// File: rtl/pc_next_unit.sv
// Program-counter register with next-PC select (jump > branch > pc+4), run/halt FSM and fetch counter.
// Latency: the next-PC selected in cycle N appears on pc after the next rising edge; pc_plus4 is combinational from pc.
// Backpressure: stall freezes pc and the counter and masks halt_req; HALT freezes everything until reset.
module pc_next_unit
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   shifted_offset,
   input  logic [25:0]       jump_index,
   input  logic              branch_taken,
   input  logic              jump,
   input  logic              stall,
   input  logic              halt_req,
   output logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   pc_plus4,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_count
);

   pc_state_t        state_q;
   pc_state_t        state_d;
   logic             pc_load;
   logic [PC_W-1:0]  branch_target;
   logic [PC_W-1:0]  jump_target;
   logic [PC_W-1:0]  next_pc;

   adder32 u_inc (
      .a   (pc),
      .b   (32'h0000_0004),
      .sum (pc_plus4)
   );

   adder32 u_branch (
      .a   (pc_plus4),
      .b   (shifted_offset),
      .sum (branch_target)
   );

   // The jump stays inside the current 256 MB region selected by pc_plus4[31:28].
   assign jump_target = {pc_plus4[31:28], jump_index, 2'b00};

   // Select the next PC: jump takes priority over branch, which takes priority over sequential.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = branch_target;
      end
   end

   // Next-state and load-enable logic: only an unstalled RUN cycle advances or accepts a halt.
   always_comb begin
      state_d = state_q;
      pc_load = 1'b0;
      if (state_q == RUN && !stall) begin
         pc_load = 1'b1;
         if (halt_req) begin
            state_d = HALT;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // PC register; the low two bits are cleared on every load so a misaligned offset cannot leak in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (pc_load) begin
         pc <= {next_pc[PC_W-1:2], 2'b00};
      end
   end

   // Fetch counter: one count per PC load, wrapping from all-ones to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (pc_load) begin
         fetch_count <= fetch_count + CNT_W'(1);
      end
   end

   assign halted = (state_q == HALT);

endmodule : pc_next_unit

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

   logic        clk;
   logic        reset;
   logic [31:0] shifted_offset;
   logic [25:0] jump_index;
   logic        branch_taken;
   logic        jump;
   logic        stall;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] pc_b;
   logic [31:0] pc_plus4_b;
   logic        halted_b;
   logic [1:0]  fetch_count_b;

   int checks;
   int errors;

   pc_next_unit #(.RESET_PC(32'h0040_0000), .CNT_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .shifted_offset (shifted_offset),
      .jump_index     (jump_index),
      .branch_taken   (branch_taken),
      .jump           (jump),
      .stall          (stall),
      .halt_req       (halt_req),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   // Narrow-counter copy driven by the same inputs, used to exercise counter wrap.
   pc_next_unit #(.RESET_PC(32'h0040_0000), .CNT_W(2)) dut_narrow (
      .clk            (clk),
      .reset          (reset),
      .shifted_offset (shifted_offset),
      .jump_index     (jump_index),
      .branch_taken   (branch_taken),
      .jump           (jump),
      .stall          (stall),
      .halt_req       (halt_req),
      .pc             (pc_b),
      .pc_plus4       (pc_plus4_b),
      .halted         (halted_b),
      .fetch_count    (fetch_count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        halt_req;
      logic        jump;
      logic        branch_taken;
      logic [31:0] offset;
      logic [25:0] idx;
      logic [31:0] exp_pc;
      logic [31:0] exp_cnt;
      logic        exp_halted;
   } vec_t;

   vec_t vecs[20];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic s, input logic h, input logic j, input logic b,
                          input logic [31:0] off, input logic [25:0] idx,
                          input logic [31:0] epc, input logic [31:0] ecnt, input logic eh);
      vecs[i].stall        = s;
      vecs[i].halt_req     = h;
      vecs[i].jump         = j;
      vecs[i].branch_taken = b;
      vecs[i].offset       = off;
      vecs[i].idx          = idx;
      vecs[i].exp_pc       = epc;
      vecs[i].exp_cnt      = ecnt;
      vecs[i].exp_halted   = eh;
   endtask

   task automatic idle_inputs();
      stall          = 1'b0;
      halt_req       = 1'b0;
      jump           = 1'b0;
      branch_taken   = 1'b0;
      shifted_offset = 32'h0;
      jump_index     = 26'h0;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //          stall halt jump br   offset         idx         exp_pc         cnt  halted
      set_vec( 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'h0040_0004, 1,  1'b0);
      set_vec( 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'h0040_0008, 2,  1'b0);
      set_vec( 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'h0040_000C, 3,  1'b0);
      set_vec( 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 26'h0,     32'h0040_0010, 4,  1'b0);
      set_vec( 4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 26'h0,     32'h0040_0004, 5,  1'b0);
      set_vec( 5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 26'h0,     32'h0040_0010, 6,  1'b0);
      set_vec( 6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 26'h0,     32'h0040_0114, 7,  1'b0);
      set_vec( 7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0FBF_FEE8, 26'h0,     32'h1000_0000, 8,  1'b0);
      set_vec( 8, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 26'h40,    32'h1000_0100, 9,  1'b0);
      set_vec( 9, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 26'h0,     32'h1000_0104, 10, 1'b0);
      set_vec(10, 1'b0, 1'b0, 1'b0, 1'b1, 32'hEFFF_FEF4, 26'h0,     32'hFFFF_FFFC, 11, 1'b0);
      set_vec(11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'h0000_0000, 12, 1'b0);
      set_vec(12, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'h0000_0000, 12, 1'b0);
      set_vec(13, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 26'h5,     32'h0000_0000, 12, 1'b0);
      set_vec(14, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 26'h0,     32'hFFFF_FFF4, 13, 1'b0);
      set_vec(15, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'hFFFF_FFF4, 13, 1'b0);
      set_vec(16, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'hFFFF_FFF8, 14, 1'b1);
      set_vec(17, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 26'h100,   32'hFFFF_FFF8, 14, 1'b1);
      set_vec(18, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 26'h0,     32'hFFFF_FFF8, 14, 1'b1);
      set_vec(19, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 26'h0,     32'hFFFF_FFF8, 14, 1'b1);

      idle_inputs();
      reset = 1'b1;
      #12;
      check32("reset_pc",       pc,                   32'h0040_0000);
      check32("reset_pc_plus4", pc_plus4,             32'h0040_0004);
      check32("reset_count",    fetch_count,          32'h0);
      check32("reset_halted",   {31'h0, halted},      32'h0);

      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         stall          = vecs[i].stall;
         halt_req       = vecs[i].halt_req;
         jump           = vecs[i].jump;
         branch_taken   = vecs[i].branch_taken;
         shifted_offset = vecs[i].offset;
         jump_index     = vecs[i].idx;
         @(posedge clk);
         #1;
         check32($sformatf("vec%0d_pc", i),     pc,          vecs[i].exp_pc);
         check32($sformatf("vec%0d_plus4", i),  pc_plus4,    vecs[i].exp_pc + 32'd4);
         check32($sformatf("vec%0d_count", i),  fetch_count, vecs[i].exp_cnt);
         check32($sformatf("vec%0d_halted", i), {31'h0, halted}, {31'h0, vecs[i].exp_halted});
         check32($sformatf("vec%0d_count2", i), {30'h0, fetch_count_b}, {30'h0, vecs[i].exp_cnt[1:0]});
      end

      // Asynchronous reset between edges while halted takes effect with no clock edge.
      @(posedge clk);
      #3;
      idle_inputs();
      reset = 1'b1;
      #1;
      check32("async_pc",     pc,              32'h0040_0000);
      check32("async_count",  fetch_count,     32'h0);
      check32("async_halted", {31'h0, halted}, 32'h0);

      // After release, a stalled first edge must not load; the next unstalled edge does.
      @(negedge clk);
      reset = 1'b0;
      stall = 1'b1;
      @(posedge clk);
      #1;
      check32("post_reset_stall_pc",    pc,          32'h0040_0000);
      check32("post_reset_stall_count", fetch_count, 32'h0);
      stall = 1'b0;
      @(posedge clk);
      #1;
      check32("post_reset_run_pc",    pc,          32'h0040_0004);
      check32("post_reset_run_count", fetch_count, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pc_next_unit
